agc_loop_ctrl: RTL and testbench
================================

Name: agc_loop_ctrl

Overview:
Automatic gain control loop stage directly downstream of the |x|^2 power stage in the amplitude-control chain. It takes the 16-bit power samples and their valid strobe, averages them over a fixed window (integrate-and-dump), and compares the average against a target window with hysteresis. It then steps a gain code up or down by one, and holds off for a settling period after every gain change so stale samples do not re-trigger the loop.

Parameters:
W_IN, 16, power sample width; samples are treated as unsigned (max legal value 0x8000 = 2*128^2).
LOG2_N, 4, log2 of averaging window length (N = 16 valid samples).
W_GAIN, 6, gain code width; legal range 0 .. 2^W_GAIN-1.
GAIN_INIT, 32, gain code after reset.
TARGET, 4096, target average power.
HYST, 512, half-width of dead band; constraint: HYST <= TARGET and TARGET+HYST <= 2^W_IN-1.
SETTLE, 8, number of valid samples discarded after each gain change; must be >= 1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
pwr_i  in  W_IN  power sample, unsigned interpretation
valid_i  in  1  pwr_i qualifier, one sample per cycle when high
enable_i  in  1  loop enable; low freezes gain and aborts the window
gain_o  out  W_GAIN  current gain code (registered)
gain_valid_o  out  1  one-cycle pulse on the cycle gain_o takes a new value
avg_o  out  W_IN  last window average (registered)
avg_valid_o  out  1  one-cycle pulse when avg_o updates
locked_o  out  1  last decision was inside the dead band
sat_o  out  1  last decision was outside the band but gain was at its limit

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, gain_o=GAIN_INIT; all other outputs 0; accumulator, sample counter and settle counter cleared.
- States: IDLE, ACCUM, DECIDE, SETTLE.
- IDLE: outputs held. If enable_i=1, go to ACCUM on the next edge. Samples arriving in IDLE are ignored.
- ACCUM:
  - Each valid_i=1 adds pwr_i to a (W_IN+LOG2_N)-bit accumulator and increments the sample counter. No overflow is possible.
  - On the edge accepting the Nth sample: avg_o = (acc+pwr_i) >> LOG2_N (truncating), avg_valid_o=1 for one cycle, accumulator and counter cleared, go to DECIDE.
- DECIDE: lasts exactly one cycle. Samples arriving in this cycle are discarded. On the edge leaving DECIDE:
  - If avg_o > TARGET+HYST: decrement gain if gain_o>0.
  - Else if avg_o < TARGET-HYST: increment gain if gain_o<2^W_GAIN-1.
  - Comparisons are strict; averages equal to either band edge are in-band.
  - locked_o=1 if in-band, else 0.
  - sat_o=1 if out of band and no step was possible, else 0.
  - If gain changed: gain_valid_o pulses for one cycle and the state goes to SETTLE with the settle counter set to SETTLE. Otherwise the state returns to ACCUM.
- SETTLE: each valid sample decrements the settle counter and is discarded. On the edge consuming the last one, go to ACCUM.
- Latency: with the Nth sample presented in cycle t, avg_valid_o is high in cycle t+1 and gain_o/gain_valid_o change in cycle t+2.
- enable_i=0 in ACCUM, DECIDE or SETTLE: go to IDLE on the next edge.
  - Accumulator and counters are cleared; the partial window is discarded.
  - gain_o, avg_o and sat_o are held; locked_o is cleared.
  - A DECIDE in progress is cancelled (no gain step).
- Gain never wraps; 0 and 2^W_GAIN-1 are hard limits.

Decomposition:
- Shared include (projectGlobalParam.v):
  - state encodings (2-bit localparams AGC_IDLE/ACCUM/DECIDE/SETTLE)
  - default TARGET/HYST constants
- Natural sub-module: power_avg. It holds the integrate-and-dump accumulator, the sample counter and avg_o/avg_valid_o generation, with a clear input driven by the FSM. The controller FSM, gain register and settle counter stay in agc_loop_ctrl.

Test Plan:
1. Reset asserted mid-operation, then released with enable_i=0 -> gain_o=32; avg_o, locked_o, sat_o, gain_valid_o all 0; no change while enable_i=0.
2. enable_i=1, 16 valid samples of 4096 -> avg_o=4096 with avg_valid_o pulse one cycle after the 16th sample; locked_o=1; gain_o stays 32; no gain_valid_o.
3. 16 samples of 8192 -> avg_o=8192; gain_o=31 two cycles after the 16th sample with gain_valid_o pulse. The next 8 valid samples do not contribute: a window of 8 junk (0) samples plus 16 samples of 4096 gives avg_o=4096.
4. Continuous samples of 1000 -> gain increments once per window (with 8-sample settle) up to 63. The next window leaves gain at 63 with sat_o=1, locked_o=0, no gain_valid_o.
5. Boundary values:
   - Window average exactly 4608 -> locked_o=1, no step.
   - Exactly 4609 -> step down.
   - Exactly 3584 -> no step.
   - All samples 0x8000 -> avg_o=32768, no overflow.
   - Gaps in valid_i -> average unaffected.
6. enable_i dropped after 7 samples, then re-raised -> next avg_valid_o only after 16 fresh samples. Async rst pulse during SETTLE -> gain_o returns to 32 immediately, state IDLE.

Source files
------------

// File: rtl/agc_loop_ctrl_pkg.sv
// Shared types and default constants for the AGC loop.
// State encoding plus the default target power window.
package agc_loop_ctrl_pkg;

  typedef enum logic [1:0] {
    AGC_IDLE   = 2'd0,
    AGC_ACCUM  = 2'd1,
    AGC_DECIDE = 2'd2,
    AGC_SETTLE = 2'd3
  } agc_state_t;

  localparam int unsigned TARGET_DEF = 4096;
  localparam int unsigned HYST_DEF   = 512;

endpackage

// File: rtl/agc_loop_ctrl_power_avg.sv
// Integrate-and-dump averager over 2^LOG2_N accepted samples.
// The average is a truncating shift of the window sum.
module agc_loop_ctrl_power_avg #(
  parameter int W_IN   = 16,
  parameter int LOG2_N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            take,
  input  logic [W_IN-1:0] pwr,
  output logic [W_IN-1:0] avg,
  output logic            avg_valid,
  output logic            done
);

  localparam int W_ACC = W_IN + LOG2_N;

  logic [W_ACC-1:0]  acc;
  logic [W_ACC-1:0]  sum;
  logic [LOG2_N-1:0] cnt;

  assign sum  = acc + W_ACC'(pwr);
  assign done = take && (cnt == {LOG2_N{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        if (done) begin
          avg       <= sum[W_ACC-1:LOG2_N];
          avg_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/agc_loop_ctrl.sv
// AGC loop controller: window average vs. hysteresis band,
// one-step gain updates and a settle hold-off after each step.
module agc_loop_ctrl
  import agc_loop_ctrl_pkg::*;
#(
  parameter int W_IN      = 16,
  parameter int LOG2_N    = 4,
  parameter int W_GAIN    = 6,
  parameter int GAIN_INIT = 32,
  parameter int TARGET    = TARGET_DEF,
  parameter int HYST      = HYST_DEF,
  parameter int SETTLE    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_IN-1:0]   pwr_i,
  input  logic              valid_i,
  input  logic              enable_i,
  output logic [W_GAIN-1:0] gain_o,
  output logic              gain_valid_o,
  output logic [W_IN-1:0]   avg_o,
  output logic              avg_valid_o,
  output logic              locked_o,
  output logic              sat_o
);

  localparam int W_CMP = W_IN + 1;
  localparam int W_SET = $clog2(SETTLE + 1);
  localparam logic [W_CMP-1:0] HI = W_CMP'(TARGET + HYST);
  localparam logic [W_CMP-1:0] LO = W_CMP'(TARGET - HYST);
  localparam logic [W_GAIN-1:0] GMAX = {W_GAIN{1'b1}};

  agc_state_t       state;
  logic [W_SET-1:0] scnt;
  logic             take;
  logic             done;
  logic             too_hi;
  logic             too_lo;
  logic             step_dn;
  logic             step_up;

  assign take    = enable_i && valid_i && (state == AGC_ACCUM);
  assign too_hi  = {1'b0, avg_o} > HI;
  assign too_lo  = {1'b0, avg_o} < LO;
  assign step_dn = too_hi && (gain_o != '0);
  assign step_up = too_lo && (gain_o != GMAX);

  agc_loop_ctrl_power_avg #(
    .W_IN   (W_IN),
    .LOG2_N (LOG2_N)
  ) u_power_avg (
    .clk       (clk),
    .rst       (rst),
    .clear     (!enable_i),
    .take      (take),
    .pwr       (pwr_i),
    .avg       (avg_o),
    .avg_valid (avg_valid_o),
    .done      (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= AGC_IDLE;
      gain_o       <= W_GAIN'(GAIN_INIT);
      gain_valid_o <= 1'b0;
      locked_o     <= 1'b0;
      sat_o        <= 1'b0;
      scnt         <= '0;
    end else begin
      gain_valid_o <= 1'b0;
      if (!enable_i) begin
        // Abort any window or pending decision; gain stays put.
        state <= AGC_IDLE;
        scnt  <= '0;
        if (state != AGC_IDLE) locked_o <= 1'b0;
      end else begin
        unique case (state)
          AGC_IDLE: state <= AGC_ACCUM;
          AGC_ACCUM: begin
            if (done) state <= AGC_DECIDE;
          end
          AGC_DECIDE: begin
            locked_o <= !(too_hi || too_lo);
            sat_o    <= (too_hi || too_lo) && !(step_dn || step_up);
            unique case (1'b1)
              step_dn: begin
                gain_o       <= gain_o - 1'b1;
                gain_valid_o <= 1'b1;
                scnt         <= W_SET'(SETTLE);
                state        <= AGC_SETTLE;
              end
              step_up: begin
                gain_o       <= gain_o + 1'b1;
                gain_valid_o <= 1'b1;
                scnt         <= W_SET'(SETTLE);
                state        <= AGC_SETTLE;
              end
              default: state <= AGC_ACCUM;
            endcase
          end
          AGC_SETTLE: begin
            if (valid_i) begin
              scnt <= scnt - 1'b1;
              if (scnt == W_SET'(1)) state <= AGC_ACCUM;
            end
          end
          default: state <= AGC_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Scenario bench for agc_loop_ctrl with an average scoreboard.
// Expected averages are queued as windows are driven.
module tb_agc_loop_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pwr;
  logic        valid;
  logic        enable;
  logic [5:0]  gain;
  logic        gain_valid;
  logic [15:0] avg;
  logic        avg_valid;
  logic        locked;
  logic        sat;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  agc_loop_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pwr_i        (pwr),
    .valid_i      (valid),
    .enable_i     (enable),
    .gain_o       (gain),
    .gain_valid_o (gain_valid),
    .avg_o        (avg),
    .avg_valid_o  (avg_valid),
    .locked_o     (locked),
    .sat_o        (sat)
  );

  // One clock with given inputs; pops the scoreboard on avg_valid.
  task automatic cyc(input logic [15:0] p, input logic v);
    logic [15:0] e;
    pwr   = p;
    valid = v;
    @(posedge clk);
    #1;
    if (avg_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL avg_unexpected got=%0d want=none", avg);
      end else begin
        e = exp_q.pop_front();
        if (avg !== e) begin
          bad++;
          $display("FAIL avg got=%0d want=%0d", avg, e);
        end
      end
    end
  endtask

  task automatic feed(input int n, input logic [15:0] p);
    repeat (n) cyc(p, 1'b1);
  endtask

  task automatic test_reset();
    enable = 1'b1;
    cyc(16'd0, 1'b0);
    exp_q.push_back(16'd8192);
    feed(16, 16'd8192);
    cyc(16'd0, 1'b0);
    total++;
    if (gain !== 6'd31) begin
      bad++;
      $display("FAIL rst_pre_gain got=%0d want=31", gain);
    end
    feed(3, 16'd0);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({gain, avg, locked, sat, gain_valid, avg_valid}
        !== {6'd32, 16'd0, 4'b0000}) begin
      bad++;
      $display("FAIL rst_state gain=%0d avg=%0d l=%b s=%b gv=%b av=%b want 32/0",
               gain, avg, locked, sat, gain_valid, avg_valid);
    end
    enable = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    feed(20, 16'd4096);
    total++;
    if ({gain, avg, locked, sat, gain_valid}
        !== {6'd32, 16'd0, 3'b000}) begin
      bad++;
      $display("FAIL rst_hold gain=%0d avg=%0d want 32/0", gain, avg);
    end
  endtask

  task automatic test_locked();
    enable = 1'b1;
    cyc(16'd0, 1'b0);
    exp_q.push_back(16'd4096);
    feed(16, 16'd4096);
    total++;
    if (avg_valid !== 1'b1) begin
      bad++;
      $display("FAIL lat_avg_valid got=%b want=1", avg_valid);
    end
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, gain_valid, locked, avg_valid} !== {6'd32, 3'b010}) begin
      bad++;
      $display("FAIL locked gain=%0d gv=%b l=%b av=%b want 32/0/1/0",
               gain, gain_valid, locked, avg_valid);
    end
  endtask

  task automatic test_step_down();
    exp_q.push_back(16'd8192);
    feed(16, 16'd8192);
    total++;
    if (gain !== 6'd32) begin
      bad++;
      $display("FAIL step_early gain=%0d want=32", gain);
    end
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, gain_valid, locked} !== {6'd31, 2'b10}) begin
      bad++;
      $display("FAIL step_dn gain=%0d gv=%b l=%b want 31/1/0",
               gain, gain_valid, locked);
    end
    feed(1, 16'd0);
    total++;
    if (gain_valid !== 1'b0) begin
      bad++;
      $display("FAIL gv_pulse got=%b want=0", gain_valid);
    end
    feed(7, 16'd0);
    exp_q.push_back(16'd4096);
    feed(16, 16'd4096);
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, locked} !== {6'd31, 1'b1}) begin
      bad++;
      $display("FAIL settle_skip gain=%0d l=%b want 31/1", gain, locked);
    end
  endtask

  task automatic test_ramp_sat();
    int g = 31;
    while (g < 63) begin
      exp_q.push_back(16'd1000);
      feed(16, 16'd1000);
      cyc(16'd1000, 1'b1);
      g++;
      total++;
      if ({gain, gain_valid} !== {6'(g), 1'b1}) begin
        bad++;
        $display("FAIL ramp gain=%0d gv=%b want %0d/1", gain, gain_valid, g);
      end
      feed(8, 16'd1000);
    end
    exp_q.push_back(16'd1000);
    feed(16, 16'd1000);
    cyc(16'd1000, 1'b1);
    total++;
    if ({gain, gain_valid, sat, locked} !== {6'd63, 3'b010}) begin
      bad++;
      $display("FAIL sat gain=%0d gv=%b s=%b l=%b want 63/0/1/0",
               gain, gain_valid, sat, locked);
    end
  endtask

  task automatic test_boundary();
    exp_q.push_back(16'd4608);
    feed(16, 16'd4608);
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, gain_valid, locked, sat} !== {6'd63, 3'b010}) begin
      bad++;
      $display("FAIL edge_hi gain=%0d l=%b s=%b want 63/1/0", gain, locked, sat);
    end
    exp_q.push_back(16'd4609);
    feed(16, 16'd4609);
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, gain_valid, locked, sat} !== {6'd62, 3'b100}) begin
      bad++;
      $display("FAIL above_hi gain=%0d gv=%b want 62/1", gain, gain_valid);
    end
    feed(8, 16'd0);
    exp_q.push_back(16'd3584);
    feed(16, 16'd3584);
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, gain_valid, locked} !== {6'd62, 2'b01}) begin
      bad++;
      $display("FAIL edge_lo gain=%0d l=%b want 62/1", gain, locked);
    end
    exp_q.push_back(16'd3583);
    feed(16, 16'd3583);
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, gain_valid, locked} !== {6'd63, 2'b10}) begin
      bad++;
      $display("FAIL below_lo gain=%0d gv=%b want 63/1", gain, gain_valid);
    end
    feed(8, 16'd0);
    exp_q.push_back(16'd32768);
    feed(16, 16'h8000);
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, gain_valid} !== {6'd62, 1'b1}) begin
      bad++;
      $display("FAIL full_scale gain=%0d want 62", gain);
    end
    feed(8, 16'd0);
    exp_q.push_back(16'd4096);
    for (int i = 0; i < 16; i++) begin
      cyc(16'hFFFF, 1'b0);
      cyc((i % 2 == 0) ? 16'd3000 : 16'd5192, 1'b1);
    end
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, locked} !== {6'd62, 1'b1}) begin
      bad++;
      $display("FAIL gaps gain=%0d l=%b want 62/1", gain, locked);
    end
    exp_q.push_back(16'd4096);
    feed(15, 16'd4096);
    feed(1, 16'd4111);
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, locked} !== {6'd62, 1'b1}) begin
      bad++;
      $display("FAIL trunc gain=%0d l=%b want 62/1", gain, locked);
    end
  endtask

  task automatic test_abort();
    feed(7, 16'd8192);
    enable = 1'b0;
    feed(1, 16'd8192);
    total++;
    if ({gain, locked, avg} !== {6'd62, 1'b0, 16'd4096}) begin
      bad++;
      $display("FAIL abort gain=%0d l=%b avg=%0d want 62/0/4096",
               gain, locked, avg);
    end
    feed(5, 16'd8192);
    enable = 1'b1;
    cyc(16'd0, 1'b0);
    exp_q.push_back(16'd4096);
    feed(15, 16'd4096);
    total++;
    if (exp_q.size() != 1) begin
      bad++;
      $display("FAIL abort_early pending=%0d want=1", exp_q.size());
    end
    feed(1, 16'd4096);
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, locked, exp_q.size() == 0} !== {6'd62, 2'b11}) begin
      bad++;
      $display("FAIL abort_win gain=%0d l=%b pending=%0d want 62/1/0",
               gain, locked, exp_q.size());
    end
  endtask

  task automatic test_rst_settle();
    exp_q.push_back(16'd8192);
    feed(16, 16'd8192);
    cyc(16'd0, 1'b0);
    total++;
    if (gain !== 6'd61) begin
      bad++;
      $display("FAIL pre_settle gain=%0d want=61", gain);
    end
    feed(3, 16'd0);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({gain, avg, locked, sat} !== {6'd32, 16'd0, 2'b00}) begin
      bad++;
      $display("FAIL rst_settle gain=%0d avg=%0d want 32/0", gain, avg);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(16'd0, 1'b0);
    exp_q.push_back(16'd4096);
    feed(16, 16'd4096);
    cyc(16'd0, 1'b0);
    total++;
    if ({gain, locked, exp_q.size() == 0} !== {6'd32, 2'b11}) begin
      bad++;
      $display("FAIL post_rst gain=%0d l=%b pending=%0d want 32/1/0",
               gain, locked, exp_q.size());
    end
  endtask

  initial begin
    rst    = 1'b0;
    enable = 1'b0;
    pwr    = '0;
    valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_locked();
    test_step_down();
    test_ramp_sat();
    test_boundary();
    test_abort();
    test_rst_settle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
